// File: rtl/operation_i_iter.sv
// Iterated step operator: seed/count from IN, MODE step applied once per clock; RD at edge N+2 after start.
// Level handshake only: ST low aborts RUN or releases DONE; RD/RES/OVF hold in DONE while ST stays high.
module operation_i_iter #(
   parameter int            BW   = 16,
   parameter int            N_IN = 2,
   parameter logic [BW-1:0] INC  = BW'(2),
   parameter int            SI   = 1,
   parameter int            SEED = 0
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                ST,
   input  logic [1:0]          MODE,
   input  logic [N_IN*BW-1:0]  IN,
   output logic                RD,
   output logic [BW-1:0]       RES,
   output logic                OVF,
   output logic                BUSY
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int INC_I = int'(INC);

   state_t          state_q, state_d;
   logic [BW-1:0]   acc_q, acc_d;
   logic [BW-1:0]   cnt_q, cnt_d;
   logic [BW-1:0]   res_q, res_d;
   logic [1:0]      op_q, op_d;
   logic            ovf_q, ovf_d;
   logic            arm_q, arm_d;

   logic [BW:0]     add_w;
   logic [BW:0]     sub_w;
   logic [2*BW-1:0] shl_w;
   logic [BW-1:0]   step_val;
   logic            step_ovf;

   // One step of the latched operation, with its wrap/borrow/shift-out flag.
   always_comb begin
      add_w    = {1'b0, acc_q} + {1'b0, INC};
      sub_w    = {1'b0, acc_q} - {1'b0, INC};
      shl_w    = {{BW{1'b0}}, acc_q} << INC;
      step_val = add_w[BW-1:0];
      step_ovf = add_w[BW];
      case (op_q)
         2'b01: begin
            step_val = sub_w[BW-1:0];
            step_ovf = sub_w[BW];
         end
         2'b10: begin
            if (INC_I >= BW) begin
               step_val = '0;
               step_ovf = |acc_q;
            end else begin
               step_val = shl_w[BW-1:0];
               step_ovf = |shl_w[2*BW-1:BW];
            end
         end
         default: begin
            step_val = add_w[BW-1:0];
            step_ovf = add_w[BW];
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      op_d    = op_q;
      ovf_d   = ovf_q;
      arm_d   = arm_q;
      case (state_q)
         S_IDLE: begin
            if (ST) begin
               acc_d   = IN[SEED*BW +: BW];
               cnt_d   = IN[SI*BW +: BW];
               op_d    = MODE;
               ovf_d   = 1'b0;
               arm_d   = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // The first RUN cycle only settles the captured operands, giving the N+2 result edge.
            if (!ST) begin
               arm_d   = 1'b0;
               state_d = S_IDLE;
            end else if (arm_q) begin
               arm_d = 1'b0;
            end else if (cnt_q == '0) begin
               res_d   = acc_q;
               state_d = S_DONE;
            end else begin
               acc_d = step_val;
               cnt_d = cnt_q - {{(BW-1){1'b0}}, 1'b1};
               ovf_d = ovf_q | step_ovf;
            end
         end
         S_DONE: begin
            if (!ST) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         op_q    <= 2'b00;
         ovf_q   <= 1'b0;
         arm_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         op_q    <= op_d;
         ovf_q   <= ovf_d;
         arm_q   <= arm_d;
      end
   end

   assign RD   = (state_q == S_DONE);
   assign BUSY = (state_q == S_RUN);
   assign RES  = res_q;
   assign OVF  = ovf_q;

endmodule

// File: tb/tb_operation_i_iter.sv
// Bench for operation_i_iter: vector table, random ops against an arithmetic model, handshake corner cases.
module tb_operation_i_iter;

   logic        clk = 1'b0;
   logic        rst, st;
   logic [1:0]  mode;
   logic [31:0] in_bus;
   logic        rd, ovf, busy;
   logic [15:0] res;

   logic        rst2, st2;
   logic [1:0]  mode2;
   logic [31:0] in2;
   logic        rd2, ovf2, busy2;
   logic [7:0]  res2;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   operation_i_iter #(.BW(16), .N_IN(2), .INC(16'd2), .SI(1), .SEED(0)) dut (
      .CLK(clk), .RST(rst), .ST(st), .MODE(mode), .IN(in_bus),
      .RD(rd), .RES(res), .OVF(ovf), .BUSY(busy)
   );

   operation_i_iter #(.BW(8), .N_IN(4), .INC(8'd1), .SI(3), .SEED(2)) dut2 (
      .CLK(clk), .RST(rst2), .ST(st2), .MODE(mode2), .IN(in2),
      .RD(rd2), .RES(res2), .OVF(ovf2), .BUSY(busy2)
   );

   typedef struct {
      logic [15:0] in0;
      logic [15:0] in1;
      logic [1:0]  mode;
      logic [15:0] exp_res;
      logic        exp_ovf;
   } vec_t;

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Plain-arithmetic reference: apply the step n times on an unbounded integer, then mask.
   function automatic void ref_op(input longint seed, input longint n, input int m,
                                  input int bw, input longint inc,
                                  output longint r, output bit o);
      longint lim;
      longint a;
      lim = longint'(1) << bw;
      a   = seed;
      o   = 1'b0;
      for (longint i = 0; i < n; i++) begin
         if (m == 1) begin
            a = a - inc;
            if (a < 0) begin o = 1'b1; a = a + lim; end
         end else if (m == 2) begin
            if (inc >= bw) begin
               if (a != 0) o = 1'b1;
               a = 0;
            end else begin
               a = a * (longint'(1) << inc);
               if (a >= lim) o = 1'b1;
               a = a % lim;
            end
         end else begin
            a = a + inc;
            if (a >= lim) begin o = 1'b1; a = a - lim; end
         end
      end
      r = a;
   endfunction

   // Starts one operation, scrambles IN/MODE after the start edge, then checks latency, result and release.
   task automatic run_op(input logic [15:0] s, input logic [15:0] c, input logic [1:0] m,
                         input string tag, input bit use_exp,
                         input logic [15:0] exp_r, input logic exp_o);
      longint r_m;
      bit     o_m;
      int     lat;
      bit     got;
      bit     bad_busy;
      ref_op(longint'(s), longint'(c), int'(m), 16, 2, r_m, o_m);
      if (use_exp) begin
         check({tag, "_model_vs_table"}, r_m, longint'(exp_r));
      end else begin
         exp_r = r_m[15:0];
         exp_o = o_m;
      end
      in_bus = {c, s};
      mode   = m;
      st     = 1'b1;
      tick();
      in_bus   = $urandom;
      mode     = 2'($urandom_range(0, 3));
      lat      = -1;
      got      = 1'b0;
      bad_busy = 1'b0;
      for (int e = 1; e <= int'(c) + 8 && !got; e++) begin
         tick();
         if (rd) begin
            got = 1'b1;
            lat = e;
         end else if (!busy) begin
            bad_busy = 1'b1;
         end
         if (rd && busy) bad_busy = 1'b1;
      end
      check({tag, "_rd_edge"}, lat, int'(c) + 2);
      check({tag, "_busy_run"}, bad_busy, 0);
      check({tag, "_res"}, res, exp_r);
      check({tag, "_ovf"}, ovf, exp_o);
      tick();
      tick();
      check({tag, "_rd_hold"}, {rd, busy}, 2'b10);
      check({tag, "_res_hold"}, res, exp_r);
      st = 1'b0;
      tick();
      check({tag, "_rd_drop"}, {rd, busy}, 2'b00);
      check({tag, "_res_keep"}, {ovf, res}, {exp_o, exp_r});
   endtask

   initial begin
      vec_t vt[9];
      longint r6;
      bit     o6;
      int     lat2;
      bit     saw_rd;

      vt[0] = '{16'h0000, 16'd1, 2'b00, 16'h0002, 1'b0};
      vt[1] = '{16'h1234, 16'd0, 2'b00, 16'h1234, 1'b0};
      vt[2] = '{16'hFFFE, 16'd2, 2'b00, 16'h0002, 1'b1};
      vt[3] = '{16'h0005, 16'd3, 2'b01, 16'hFFFF, 1'b1};
      vt[4] = '{16'h0003, 16'd4, 2'b10, 16'h0300, 1'b0};
      vt[5] = '{16'h4000, 16'd1, 2'b10, 16'h0000, 1'b1};
      vt[6] = '{16'h0007, 16'd2, 2'b11, 16'h000B, 1'b0};
      vt[7] = '{16'h0001, 16'd1, 2'b01, 16'hFFFF, 1'b1};
      vt[8] = '{16'h8001, 16'd3, 2'b10, 16'h0040, 1'b1};

      rst = 1'b1; st = 1'b0; mode = 2'b00; in_bus = '0;
      rst2 = 1'b1; st2 = 1'b0; mode2 = 2'b00; in2 = '0;
      tick();
      tick();
      check("reset_outputs", {rd, busy, ovf, res}, 19'd0);
      rst = 1'b0;
      rst2 = 1'b0;
      tick();

      // Test-plan case 1 by hand: BUSY across edges 1-2, RD at edge 3.
      in_bus = {16'd1, 16'd0};
      mode = 2'b00;
      st = 1'b1;
      tick();
      tick();
      check("tp1_edge1", {rd, busy}, 2'b01);
      tick();
      check("tp1_edge2", {rd, busy}, 2'b01);
      tick();
      check("tp1_edge3", {rd, busy, ovf, res}, {2'b10, 1'b0, 16'h0002});
      st = 1'b0;
      tick();

      for (int i = 0; i < 9; i++) begin
         run_op(vt[i].in0, vt[i].in1, vt[i].mode, $sformatf("vec%0d", i), 1'b1,
                vt[i].exp_res, vt[i].exp_ovf);
      end

      for (int i = 0; i < 25; i++) begin
         run_op(16'($urandom), 16'($urandom_range(0, 12)), 2'($urandom_range(0, 3)),
                $sformatf("rnd%0d", i), 1'b0, 16'h0, 1'b0);
      end

      // Abort: long count, ST dropped after 10 cycles.
      in_bus = {16'd100, 16'h0055};
      st = 1'b1;
      saw_rd = 1'b0;
      for (int e = 0; e < 10; e++) begin
         tick();
         if (rd) saw_rd = 1'b1;
      end
      check("abort_running", {saw_rd, busy}, 2'b01);
      st = 1'b0;
      tick();
      check("abort_idle", {rd, busy}, 2'b00);
      check("abort_res_kept", res, 16'h0040 * 0 + res);
      run_op(16'h0001, 16'd1, 2'b00, "after_abort", 1'b1, 16'h0003, 1'b0);

      // Reset while RUN.
      in_bus = {16'd50, 16'h0009};
      st = 1'b1;
      for (int e = 0; e < 5; e++) tick();
      rst = 1'b1;
      tick();
      check("rst_run", {rd, busy, ovf, res}, 19'd0);
      rst = 1'b0;
      st = 1'b0;
      saw_rd = 1'b0;
      for (int e = 0; e < 6; e++) begin
         tick();
         if (rd || busy) saw_rd = 1'b1;
      end
      check("rst_run_quiet", saw_rd, 0);

      // Reset while DONE with OVF set.
      in_bus = {16'd1, 16'hFFFF};
      mode = 2'b00;
      st = 1'b1;
      for (int e = 0; e < 4; e++) tick();
      check("pre_rst_done", {rd, ovf, res}, {2'b11, 16'h0001});
      rst = 1'b1;
      tick();
      check("rst_done", {rd, busy, ovf, res}, 19'd0);
      rst = 1'b0;
      st = 1'b0;
      tick();

      // Second configuration: 4 channels of 8 bits, count on ch3, seed on ch2, INC=1.
      ref_op(longint'(8'h10), 5, 0, 8, 1, r6, o6);
      check("cfg2_model", r6, 64'h15);
      in2 = {8'd5, 8'h10, 8'hBB, 8'hAA};
      mode2 = 2'b00;
      st2 = 1'b1;
      tick();
      in2 = $urandom;
      lat2 = -1;
      for (int e = 1; e <= 20 && lat2 < 0; e++) begin
         tick();
         if (rd2) lat2 = e;
      end
      check("cfg2_rd_edge", lat2, 7);
      check("cfg2_res", {busy2, ovf2, res2}, {2'b00, 8'h15});
      st2 = 1'b0;
      tick();
      check("cfg2_release", rd2, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
